// File: rtl/ascon_perm_engine.sv
// ascon_perm_engine: iterative Ascon permutation (p^12 / p^8 / p^6), UNROLL rounds per clock.
package ascon_perm_pkg;
  typedef logic [0:4][63:0] type_state;
endpackage

module ascon_perm_engine
  import ascon_perm_pkg::*;
#(
  parameter int UNROLL        = 1,
  parameter int NB_ROUNDS_MAX = 12
) (
  input  logic       clock_i,
  input  logic       reset_i,
  input  logic       start_i,
  input  logic [1:0] mode_i,
  input  type_state  state_i,
  output type_state  state_o,
  output logic       valid_o,
  output logic       busy_o,
  output logic [3:0] round_o
);
  if (UNROLL != 1 && UNROLL != 2) begin : g_bad_unroll
    $error("ascon_perm_engine: UNROLL must be 1 or 2");
  end
  if (NB_ROUNDS_MAX != 12) begin : g_bad_rounds
    $error("ascon_perm_engine: NB_ROUNDS_MAX must be 12");
  end

  typedef enum logic [1:0] {IDLE, RUN, DONE} fsm_t;

  function automatic logic [63:0] ror(input logic [63:0] x, input int n);
    logic [127:0] d;
    d = {x, x};
    return d[n +: 64];
  endfunction

  function automatic type_state ascon_round(input type_state s, input logic [3:0] i);
    logic [63:0] x0, x1, x2, x3, x4, t0, t1, t2, t3, t4;
    x0 = s[0];
    x1 = s[1];
    x2 = s[2] ^ {56'h0, 4'hF - i, i};
    x3 = s[3];
    x4 = s[4];
    // bitsliced 5-bit S-box over all 64 columns at once
    x0 ^= x4;
    x4 ^= x3;
    x2 ^= x1;
    t0 = ~x0 & x1;
    t1 = ~x1 & x2;
    t2 = ~x2 & x3;
    t3 = ~x3 & x4;
    t4 = ~x4 & x0;
    x0 ^= t1;
    x1 ^= t2;
    x2 ^= t3;
    x3 ^= t4;
    x4 ^= t0;
    x1 ^= x0;
    x0 ^= x4;
    x3 ^= x2;
    x2 = ~x2;
    return {x0 ^ ror(x0, 19) ^ ror(x0, 28),
            x1 ^ ror(x1, 61) ^ ror(x1, 39),
            x2 ^ ror(x2, 1)  ^ ror(x2, 6),
            x3 ^ ror(x3, 10) ^ ror(x3, 17),
            x4 ^ ror(x4, 7)  ^ ror(x4, 41)};
  endfunction

  fsm_t       fsm;
  type_state  chain [UNROLL+1];
  logic [3:0] nxt_round;
  logic [3:0] start_round;

  assign chain[0] = state_o;
  for (genvar j = 0; j < UNROLL; j++) begin : g_round
    assign chain[j+1] = ascon_round(chain[j], round_o + 4'(j));
  end

  assign nxt_round   = round_o + 4'(UNROLL);
  assign start_round = mode_i == 2'b01 ? 4'd4 : mode_i == 2'b10 ? 4'd6 : 4'd0;

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      fsm     <= IDLE;
      state_o <= '0;
      round_o <= '0;
      valid_o <= 1'b0;
      busy_o  <= 1'b0;
    end else if (fsm == RUN) begin
      state_o <= chain[UNROLL];
      round_o <= nxt_round;
      if (nxt_round == 4'(NB_ROUNDS_MAX)) begin
        fsm     <= DONE;
        busy_o  <= 1'b0;
        valid_o <= 1'b1;
      end
    end else if (start_i) begin
      fsm     <= RUN;
      state_o <= state_i;
      round_o <= start_round;
      busy_o  <= 1'b1;
      valid_o <= 1'b0;
    end else begin
      fsm     <= IDLE;
      valid_o <= 1'b0;
    end
  end
endmodule

// File: tb/tb_ascon_perm_engine.sv
// tb_ascon_perm_engine: directed checks of UNROLL=1 and UNROLL=2 engines against a table-driven reference.
module tb_ascon_perm_engine;
  import ascon_perm_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [1:0] mode = 2'b00;
  type_state  st = '0;
  type_state  s1, s2;
  logic       v1, v2, b1, b2;
  logic [3:0] r1, r2;
  int         checks = 0;
  int         errs = 0;

  localparam type_state V    = {64'h80400C0600000000, 256'h0};
  localparam type_state JUNK = {5{64'hDEADBEEFCAFEF00D}};
  localparam logic [4:0] SBOX [32] = '{
    5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
    5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
    5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
    5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17};

  always #5 clk = ~clk;

  ascon_perm_engine #(.UNROLL(1)) u1 (
    .clock_i(clk), .reset_i(rst), .start_i(start), .mode_i(mode), .state_i(st),
    .state_o(s1), .valid_o(v1), .busy_o(b1), .round_o(r1));

  ascon_perm_engine #(.UNROLL(2)) u2 (
    .clock_i(clk), .reset_i(rst), .start_i(start), .mode_i(mode), .state_i(st),
    .state_o(s2), .valid_o(v2), .busy_o(b2), .round_o(r2));

  task automatic check(input string tag, input logic [319:0] got, input logic [319:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] rr(input logic [63:0] x, input int n);
    return (x >> n) | (x << (64 - n));
  endfunction

  function automatic type_state ref_perm(input type_state s, input int nr);
    logic [4:0] c;
    for (int r = 12 - nr; r < 12; r++) begin
      s[2] ^= 64'((15 - r) * 16 + r);
      for (int b = 0; b < 64; b++) begin
        c = SBOX[{s[0][b], s[1][b], s[2][b], s[3][b], s[4][b]}];
        for (int w = 0; w < 5; w++) s[w][b] = c[4-w];
      end
      s[0] ^= rr(s[0], 19) ^ rr(s[0], 28);
      s[1] ^= rr(s[1], 61) ^ rr(s[1], 39);
      s[2] ^= rr(s[2], 1) ^ rr(s[2], 6);
      s[3] ^= rr(s[3], 10) ^ rr(s[3], 17);
      s[4] ^= rr(s[4], 7) ^ rr(s[4], 41);
    end
    return s;
  endfunction

  task automatic run_job(input logic [1:0] m, input type_state s, input string tag);
    int a;
    int lat1, lat2, n1, n2, bad;
    type_state exp, res1, res2;
    a = m == 2'b01 ? 8 : m == 2'b10 ? 6 : 12;
    exp = ref_perm(s, a);
    lat1 = -1; lat2 = -1; n1 = 0; n2 = 0; bad = 0;
    res1 = '0; res2 = '0;
    @(negedge clk);
    mode = m; st = s; start = 1'b1;
    @(negedge clk);
    start = 1'b0; st = JUNK; mode = ~m;
    for (int k = 0; k < 30; k++) begin
      if (v1) begin n1++; if (lat1 < 0) begin lat1 = k; res1 = s1; end end
      if (v2) begin n2++; if (lat2 < 0) begin lat2 = k; res2 = s2; end end
      if (k <= a && r1 !== 4'(12 - a + k)) bad++;
      if (k <= a / 2 && r2 !== 4'(12 - a + 2 * k)) bad++;
      if (k < a && !b1) bad++;
      if (k < a / 2 && !b2) bad++;
      if ((v1 && b1) || (v2 && b2)) bad++;
      @(negedge clk);
    end
    check({tag, "_lat1"}, lat1, a);
    check({tag, "_lat2"}, lat2, a / 2);
    check({tag, "_pulses1"}, n1, 1);
    check({tag, "_pulses2"}, n2, 1);
    check({tag, "_res1"}, res1, exp);
    check({tag, "_res2"}, res2, exp);
    check({tag, "_seq"}, bad, 0);
  endtask

  initial begin
    type_state exp6;
    int last1, last2, n1, n2, bad;
    exp6 = ref_perm(V, 6);
    start = 1'b1;
    @(negedge clk);
    check("rst_s1", s1, '0);
    check("rst_s2", s2, '0);
    check("rst_ctl", {r1, r2, v1, v2, b1, b2}, '0);
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    @(negedge clk);
    check("rel_idle", {b1, b2, v1, v2}, '0);

    run_job(2'b00, '0, "p12_zero");
    run_job(2'b10, V, "p6");
    run_job(2'b01, V, "p8");
    run_job(2'b11, V, "p12_rsv");

    // continuous start, mode 10; state_i scrambled whenever both engines are mid-run
    last1 = -1; last2 = -1; n1 = 0; n2 = 0; bad = 0;
    @(negedge clk);
    mode = 2'b10; st = V; start = 1'b1;
    @(negedge clk);
    for (int k = 0; k <= 40; k++) begin
      if (v1) begin
        if (last1 >= 0 && k - last1 != 7) bad++;
        if (s1 !== exp6) bad++;
        last1 = k; n1++;
      end
      if (v2) begin
        if (last2 >= 0 && k - last2 != 4) bad++;
        if (s2 !== exp6) bad++;
        last2 = k; n2++;
      end
      if ((v1 && b1) || (v2 && b2)) bad++;
      st = (b1 && b2) ? JUNK : V;
      @(negedge clk);
    end
    check("cont_pulses1", n1, 5);
    check("cont_pulses2", n2, 10);
    check("cont_bad", bad, 0);
    start = 1'b0;
    repeat (20) @(negedge clk);

    // abort a 12-round job at RUN cycle 5
    mode = 2'b00; st = V; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    check("pre_abort_busy", {b1, b2}, 2'b11);
    #2 rst = 1'b1;
    #1;
    check("abort_s1", s1, '0);
    check("abort_s2", s2, '0);
    check("abort_ctl", {r1, r2, v1, v2, b1, b2}, '0);
    @(negedge clk);
    rst = 1'b0;
    bad = 0;
    for (int k = 0; k < 20; k++) begin
      if (v1 || v2 || b1 || b2) bad++;
      @(negedge clk);
    end
    check("abort_quiet", bad, 0);
    run_job(2'b00, V, "p12_after_abort");

    $display("Simulation finished: %0d checks, %0d errors", checks, errs);
    $finish;
  end
endmodule
